// File: rtl/imem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_ctrl_pkg
//  Description : Shared types and default geometry for the instruction-RAM
//                access controller (FSM states, arbitration owner).
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_ctrl_pkg;

    localparam int unsigned IMEM_DEPTH  = 1024;
    localparam int unsigned IMEM_ADDR_W = 16;
    localparam int unsigned IMEM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    typedef enum logic {
        OWN_LOADER = 1'b0,
        OWN_FETCH  = 1'b1
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/imem_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : imem_rr_arb
//  Description : Two-requester grant logic (loader vs fetch). With
//                IMEM_ARB_RR_EN defined, ties are resolved round-robin using
//                a one-bit last_owner history; otherwise the loader always
//                wins ties.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_rr_arb
    import imem_ctrl_pkg::*;
(
`ifdef IMEM_ARB_RR_EN
    input  logic clk,
    input  logic reset,
`endif
    input  logic en_i,
    input  logic ld_req_i,
    input  logic fe_req_i,
    output logic ld_gnt_o,
    output logic fe_gnt_o
);

`ifdef IMEM_ARB_RR_EN
    owner_e last_owner_q;
    owner_e last_owner_d;

    // Tie goes to whoever did not win the previous grant; history follows every grant.
    always_comb begin
        ld_gnt_o     = 1'b0;
        fe_gnt_o     = 1'b0;
        last_owner_d = last_owner_q;
        if (en_i) begin
            if (ld_req_i && fe_req_i) begin
                ld_gnt_o = (last_owner_q == OWN_FETCH);
                fe_gnt_o = (last_owner_q == OWN_LOADER);
            end else begin
                ld_gnt_o = ld_req_i;
                fe_gnt_o = fe_req_i;
            end
        end
        if (ld_gnt_o) begin
            last_owner_d = OWN_LOADER;
        end else if (fe_gnt_o) begin
            last_owner_d = OWN_FETCH;
        end
    end

    // History register; resets to fetch so the loader takes the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWN_FETCH;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    // Fixed priority: loader first, fetch only when the loader is silent.
    always_comb begin
        ld_gnt_o = en_i & ld_req_i;
        fe_gnt_o = en_i & fe_req_i & ~ld_req_i;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/imem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_access_ctrl
//  Description : Sequencer/arbiter owning the instruction RAM port. Serves
//                loader writes, fetch reads (registered return data) and a
//                whole-RAM zero-fill. Arbitration mode selected by the
//                IMEM_ARB_RR_EN macro (defined: round-robin, else fixed).
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_access_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_err,
    input  logic              fe_req,
    output logic              fe_gnt,
    input  logic [ADDR_W-1:0] fe_addr,
    output logic [DATA_W-1:0] fe_rdata,
    output logic              fe_rvalid,
    output logic              fe_err,
    input  logic              clr_start,
    output logic              clr_done,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    state_e            state_q,       state_d;
    logic [ADDR_W-1:0] ram_addr_q,    ram_addr_d;
    logic [DATA_W-1:0] ram_data_q,    ram_data_d;
    logic              ram_we_q,      ram_we_d;
    logic              ld_err_q,      ld_err_d;
    logic [DATA_W-1:0] fe_rdata_q,    fe_rdata_d;
    logic              fe_rvalid_q,   fe_rvalid_d;
    logic              fe_err_q,      fe_err_d;
    logic              fe_oor_q,      fe_oor_d;
    logic              clr_pending_q, clr_pending_d;
    logic              clr_done_q,    clr_done_d;
    logic              busy_q;

    logic w_clr_req;
    logic w_grant_en;
    logic w_ld_in_range;
    logic w_fe_in_range;

    // A clear request (stored or arriving now) blocks all handshake grants.
    assign w_clr_req     = clr_pending_q | clr_start;
    assign w_grant_en    = (state_q == ST_IDLE) & ~w_clr_req & ~reset;
    assign w_ld_in_range = (ld_addr <= c_last_addr);
    assign w_fe_in_range = (fe_addr <= c_last_addr);

    imem_rr_arb u_arb (
`ifdef IMEM_ARB_RR_EN
        .clk      (clk),
        .reset    (reset),
`endif
        .en_i     (w_grant_en),
        .ld_req_i (ld_valid),
        .fe_req_i (fe_req),
        .ld_gnt_o (ld_ready),
        .fe_gnt_o (fe_gnt)
    );

    // Next-state and registered-output decode; RAM port values are captured
    // one edge early so they appear as clean registers during WRITE/READ/CLEAR.
    always_comb begin
        state_d       = state_q;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        ram_we_d      = 1'b0;
        ld_err_d      = 1'b0;
        fe_rdata_d    = fe_rdata_q;
        fe_rvalid_d   = 1'b0;
        fe_err_d      = 1'b0;
        fe_oor_d      = fe_oor_q;
        clr_pending_d = clr_pending_q | clr_start;
        clr_done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (w_clr_req) begin
                    state_d       = ST_CLEAR;
                    ram_addr_d    = '0;
                    ram_data_d    = '0;
                    ram_we_d      = 1'b1;
                    clr_pending_d = 1'b0;
                end else if (ld_valid && ld_ready) begin
                    state_d    = ST_WRITE;
                    ram_addr_d = ld_addr;
                    ram_data_d = ld_data;
                    ram_we_d   = w_ld_in_range;
                    ld_err_d   = ~w_ld_in_range;
                end else if (fe_req && fe_gnt) begin
                    state_d    = ST_READ;
                    ram_addr_d = fe_addr;
                    fe_oor_d   = ~w_fe_in_range;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_READ: begin
                state_d     = ST_IDLE;
                fe_rvalid_d = 1'b1;
                fe_err_d    = fe_oor_q;
                fe_rdata_d  = fe_oor_q ? '0 : ram_rdata;
            end
            ST_CLEAR: begin
                if (ram_addr_q == c_last_addr) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    ram_we_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            ram_we_q      <= 1'b0;
            ld_err_q      <= 1'b0;
            fe_rdata_q    <= '0;
            fe_rvalid_q   <= 1'b0;
            fe_err_q      <= 1'b0;
            fe_oor_q      <= 1'b0;
            clr_pending_q <= 1'b0;
            clr_done_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            ram_we_q      <= ram_we_d;
            ld_err_q      <= ld_err_d;
            fe_rdata_q    <= fe_rdata_d;
            fe_rvalid_q   <= fe_rvalid_d;
            fe_err_q      <= fe_err_d;
            fe_oor_q      <= fe_oor_d;
            clr_pending_q <= clr_pending_d;
            clr_done_q    <= clr_done_d;
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign ram_we    = ram_we_q;
    assign ld_err    = ld_err_q;
    assign fe_rdata  = fe_rdata_q;
    assign fe_rvalid = fe_rvalid_q;
    assign fe_err    = fe_err_q;
    assign clr_done  = clr_done_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
